// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - States, opcodes, default step table and error codes for ctrl_sequencer
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_RST, S_F0, S_F1, S_F2, S_DEC, S_EXEC, S_HALT, S_ERR
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                           OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
                           OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000,
                           OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011,
                           OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110,
                           OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001,
                           OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JAL  = 5'b10100,
                           OP_JR   = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111,
                           OP_MFLO = 5'b11000, OP_MFHI = 5'b11001, OP_NOP  = 5'b11010,
                           OP_HALT = 5'b11011;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Entry k sits at bits [3k +: 3]; listed from opcode 31 down to opcode 0.
    localparam logic [95:0] STEP_TABLE_DEF = {
        3'd0, 3'd0, 3'd0, 3'd0,                         // 11111..11100 reserved
        3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1,       // halt nop mfhi mflo out in jr
        3'd2, 3'd3, 3'd2, 3'd2, 3'd4, 3'd4,             // jal br not neg mul div
        3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3,       // ori andi addi shl shra shr rol
        3'd3, 3'd3, 3'd3, 3'd3, 3'd3,                   // ror or and sub add
        3'd4, 3'd3, 3'd5                                // st ldi ld
    };

endpackage

// File: rtl/ctrl_sequencer_if.sv
// rtl/ctrl_sequencer_if.sv - Instruction/memory inputs and control strobes of ctrl_sequencer
interface ctrl_sequencer_if #(
    parameter int IRW   = 32,
    parameter int OPW   = 5,
    parameter int STEPW = 3,
    parameter int CNTW  = 32
);
    logic [IRW-1:0]   IR;
    logic             Mem_Ready;
    logic             Stop;
    logic             Resume;
    logic             PCout, MARin, IncPC, Zin;
    logic             Zlowout, PCin, Read, MDRin;
    logic             MDRout, IRin;
    logic             exec_valid;
    logic [OPW-1:0]   opcode;
    logic [STEPW-1:0] step;
    logic             Run;
    logic [1:0]       err;
    logic [CNTW-1:0]  instr_count;

    modport master (
        input  IR, Mem_Ready, Stop, Resume,
        output PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin,
        output exec_valid, opcode, step, Run, err, instr_count
    );

    modport slave (
        output IR, Mem_Ready, Stop, Resume,
        input  PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin,
        input  exec_valid, opcode, step, Run, err, instr_count
    );
endinterface

// File: rtl/ctrl_fetch_wait.sv
// rtl/ctrl_fetch_wait.sv - F1 memory wait counter with timeout detection
module ctrl_fetch_wait #(
    parameter int MEM_WAIT    = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic Clock,
    input  logic Reset,
    input  logic f1_active,
    input  logic mem_ready,
    output logic ready,
    output logic timeout
);
    localparam int CW = ($clog2(MEM_TIMEOUT + 1) < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] wait_cnt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            wait_cnt <= '0;
        else if (!f1_active)
            wait_cnt <= '0;
        else if (!mem_ready && wait_cnt != LIMIT)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Ready takes priority over timeout when both land on the limit cycle.
    assign ready   = (MEM_WAIT != 0) ? mem_ready : 1'b1;
    assign timeout = (MEM_WAIT != 0) && f1_active && !mem_ready && (wait_cnt == LIMIT);
endmodule

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - Multicycle fetch/decode/execute sequencer for the Mini-SRC datapath
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int                          IRW         = 32,
    parameter int                          OPW         = 5,
    parameter int                          STEPW       = 3,
    parameter logic [(2**OPW)*STEPW-1:0]   STEP_TABLE  = STEP_TABLE_DEF,
    parameter logic [OPW-1:0]              HALT_OP     = OP_HALT,
    parameter int                          MEM_WAIT    = 1,
    parameter int                          MEM_TIMEOUT = 15,
    parameter int                          CNTW        = 32
) (
    input  logic               Clock,
    input  logic               Reset,
    ctrl_sequencer_if.master   bus
);
    state_t           state_q, state_d;
    logic [OPW-1:0]   opcode_q;
    logic [STEPW-1:0] step_q;
    logic [CNTW-1:0]  count_q;
    logic [1:0]       err_q;
    logic             f1_first_q;
    logic             in_f1, mem_ok, mem_timeout;
    logic [OPW-1:0]   ir_op;
    logic [STEPW-1:0] ir_steps, last_step;

    assign ir_op     = bus.IR[IRW-1 -: OPW];
    assign ir_steps  = STEP_TABLE[ir_op*STEPW +: STEPW];
    assign last_step = STEP_TABLE[opcode_q*STEPW +: STEPW] - 1'b1;
    assign in_f1     = (state_q == S_F1);

    ctrl_fetch_wait #(
        .MEM_WAIT    (MEM_WAIT),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_fetch_wait (
        .Clock     (Clock),
        .Reset     (Reset),
        .f1_active (in_f1),
        .mem_ready (bus.Mem_Ready),
        .ready     (mem_ok),
        .timeout   (mem_timeout)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state_q <= S_RST;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.PCout       = 1'b0;
        bus.MARin       = 1'b0;
        bus.IncPC       = 1'b0;
        bus.Zin         = 1'b0;
        bus.Zlowout     = 1'b0;
        bus.PCin        = 1'b0;
        bus.Read        = 1'b0;
        bus.MDRin       = 1'b0;
        bus.MDRout      = 1'b0;
        bus.IRin        = 1'b0;
        bus.exec_valid  = 1'b0;
        bus.Run         = 1'b0;
        case (state_q)
            S_RST:  state_d = S_F0;
            S_F0: begin
                {bus.PCout, bus.MARin, bus.IncPC, bus.Zin} = 4'b1111;
                bus.Run = 1'b1;
                state_d = S_F1;
            end
            S_F1: begin
                // PC update happens once; the read strobes stretch over wait states.
                bus.Zlowout = f1_first_q;
                bus.PCin    = f1_first_q;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                bus.Run     = 1'b1;
                if (mem_ok)
                    state_d = S_F2;
                else if (mem_timeout)
                    state_d = S_ERR;
            end
            S_F2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                bus.Run    = 1'b1;
                state_d    = S_DEC;
            end
            S_DEC: begin
                bus.Run = 1'b1;
                if (ir_op == HALT_OP)
                    state_d = S_HALT;
                else if (ir_steps == '0)
                    state_d = S_ERR;
                else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                bus.exec_valid = 1'b1;
                bus.Run        = 1'b1;
                if (step_q == last_step)
                    state_d = bus.Stop ? S_HALT : S_F0;
            end
            S_HALT: begin
                if (bus.Resume && !bus.Stop)
                    state_d = S_F0;
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            opcode_q   <= '0;
            step_q     <= '0;
            count_q    <= '0;
            err_q      <= ERR_NONE;
            f1_first_q <= 1'b0;
        end else begin
            f1_first_q <= (state_q == S_F0);
            case (state_q)
                S_F1: begin
                    if (!mem_ok && mem_timeout)
                        err_q <= ERR_TIMEOUT;
                end
                S_DEC: begin
                    opcode_q <= ir_op;
                    if (ir_op == HALT_OP)
                        count_q <= count_q + 1'b1;
                    else if (ir_steps == '0)
                        err_q <= ERR_ILLEGAL;
                    else
                        step_q <= '0;
                end
                S_EXEC: begin
                    if (step_q == last_step)
                        count_q <= count_q + 1'b1;
                    else
                        step_q <= step_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.opcode      = opcode_q;
    assign bus.step        = step_q;
    assign bus.err         = err_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - Self-checking randomized bench for ctrl_sequencer
module tb_ctrl_sequencer;
    localparam int TMO = 15;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    ctrl_sequencer_if #(.IRW(32), .OPW(5), .STEPW(3), .CNTW(32)) bus ();

    ctrl_sequencer #(
        .IRW(32), .OPW(5), .STEPW(3), .MEM_WAIT(1), .MEM_TIMEOUT(TMO), .CNTW(32)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          steps_of [32];
    logic [31:0] exp_count;

    // {PCout,MARin,IncPC,Zin, Zlowout,PCin,Read,MDRin, MDRout,IRin,exec_valid,Run}
    logic [11:0] obs;
    logic [53:0] all_out;
    assign obs = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin,
                  bus.Zlowout, bus.PCin, bus.Read, bus.MDRin,
                  bus.MDRout, bus.IRin, bus.exec_valid, bus.Run};
    assign all_out = {obs, bus.opcode, bus.step, bus.err, bus.instr_count};

    // Expected strobes for cycle c of an instruction (c=0 is F0) with `waits` F1 wait cycles.
    function automatic logic [11:0] exp_strobe(input int c, input int waits);
        if (c == 0)              return 12'b1111_0000_0001;
        if (c == 1)              return 12'b0000_1111_0001;
        if (c <= 1 + waits)      return 12'b0000_0011_0001;
        if (c == 2 + waits)      return 12'b0000_0000_1101;
        if (c == 3 + waits)      return 12'b0000_0000_0001;
        return 12'b0000_0000_0011;
    endfunction

    task automatic run_instr(input logic [4:0] op, input int waits, input int stop_step,
                             input int abort_cycle);
        int n, total;
        logic is_halt, illegal;
        logic [2:0] es;
        logic [31:0] ir;
        n       = steps_of[op];
        is_halt = (op == 5'd27);
        illegal = !is_halt && (n == 0);
        total   = 4 + waits + n;
        for (int c = 0; c < total; c++) begin
            @(negedge Clock);
            checks++;
            if (obs !== exp_strobe(c, waits)) begin
                errors++;
                $display("FAIL strobes op=%0d cycle=%0d: got %b expected %b",
                         op, c, obs, exp_strobe(c, waits));
            end
            if (c == 0) begin
                checks++;
                if (bus.instr_count !== exp_count) begin
                    errors++;
                    $display("FAIL instr_count at F0: got %0d expected %0d", bus.instr_count, exp_count);
                end
                checks++;
                if (bus.err !== 2'b00) begin
                    errors++;
                    $display("FAIL err at F0: got %b expected 00", bus.err);
                end
            end
            if (c >= 4 + waits) begin
                es = 3'(c - 4 - waits);
                checks++;
                if (bus.step !== es) begin
                    errors++;
                    $display("FAIL step op=%0d cycle=%0d: got %0d expected %0d", op, c, bus.step, es);
                end
            end
            if (c == 4 + waits) begin
                checks++;
                if (bus.opcode !== op) begin
                    errors++;
                    $display("FAIL opcode in EXEC: got %0d expected %0d", bus.opcode, op);
                end
            end
            if (c == abort_cycle) begin
                Reset = 1'b1;
                #1;
                checks++;
                if (all_out !== '0) begin
                    errors++;
                    $display("FAIL async reset outputs: got %h expected 0", all_out);
                end
                return;
            end
            bus.Resume    = 1'($urandom_range(0, 1));
            bus.Mem_Ready = (c >= 1 && c <= 1 + waits) ? (c - 1 >= waits) : 1'($urandom_range(0, 1));
            ir = $urandom;
            if (c == 3 + waits) ir[31:27] = op;
            bus.IR = ir;
            if (c >= 4 + waits)
                bus.Stop = (stop_step >= 0) && (c - 4 - waits >= stop_step);
            else
                bus.Stop = 1'($urandom_range(0, 1));
        end
        if (!illegal) exp_count++;
    endtask

    task automatic check_halt_then_resume(input logic [4:0] exp_op);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            checks++;
            if (obs !== 12'b0) begin
                errors++;
                $display("FAIL halt strobes/Run: got %b expected 0", obs);
            end
            checks++;
            if (bus.instr_count !== exp_count || bus.opcode !== exp_op) begin
                errors++;
                $display("FAIL halt count/opcode: got %0d/%0d expected %0d/%0d",
                         bus.instr_count, bus.opcode, exp_count, exp_op);
            end
            bus.Stop   = (i < 2);
            bus.Resume = (i != 2);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.IR = '0; bus.Mem_Ready = 1'b0; bus.Stop = 1'b0; bus.Resume = 1'b0;
        exp_count = '0;
        repeat (3) @(negedge Clock);
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset outputs: got %h expected 0", all_out);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL RST after release: got %h expected 0", all_out);
        end
    endtask

    task automatic test_add();
        run_instr(5'd3, 0, -1, -1);
    endtask

    task automatic test_wait();
        run_instr(5'($urandom_range(0, 26)), 2, -1, -1);
        run_instr(5'($urandom_range(0, 26)), TMO, -1, -1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 15; k++)
            run_instr(5'($urandom_range(0, 26)), int'($urandom_range(0, 4)), -1, -1);
    endtask

    task automatic test_stop_halt();
        run_instr(5'd16, 0, 1, -1);
        check_halt_then_resume(5'd16);
        run_instr(5'd27, int'($urandom_range(0, 3)), -1, -1);
        check_halt_then_resume(5'd27);
        run_instr(5'd3, 1, -1, -1);
    endtask

    task automatic test_illegal();
        run_instr(5'd31, int'($urandom_range(0, 2)), -1, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            checks++;
            if (obs !== 12'b0 || bus.err !== 2'b01 || bus.opcode !== 5'd31) begin
                errors++;
                $display("FAIL illegal ERR: strobes %b err %b opcode %0d expected 0/01/31",
                         obs, bus.err, bus.opcode);
            end
            bus.Resume = 1'($urandom_range(0, 1));
            bus.Stop   = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_timeout();
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        checks++;
        if (bus.err !== 2'b00) begin
            errors++;
            $display("FAIL err after reset: got %b expected 00", bus.err);
        end
        @(negedge Clock);
        Reset = 1'b0;
        exp_count = '0;
        bus.Stop = 1'b0;
        for (int c = 0; c <= TMO + 1; c++) begin
            @(negedge Clock);
            checks++;
            if (obs !== exp_strobe(c, 1000)) begin
                errors++;
                $display("FAIL timeout fetch cycle=%0d: got %b expected %b", c, obs, exp_strobe(c, 1000));
            end
            bus.Mem_Ready = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            checks++;
            if (obs !== 12'b0 || bus.err !== 2'b10) begin
                errors++;
                $display("FAIL timeout ERR: strobes %b err %b expected 0/10", obs, bus.err);
            end
            bus.Mem_Ready = 1'b1;
            bus.Resume    = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        exp_count = '0;
        run_instr(5'd3, 1, -1, -1);
        run_instr(5'd0, 0, -1, 7);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL RST after mid reset: got %h expected 0", all_out);
        end
        exp_count = '0;
        run_instr(5'd3, 0, -1, -1);
        run_instr(5'd1, 0, -1, -1);
        @(negedge Clock);
        checks++;
        if (bus.instr_count !== exp_count) begin
            errors++;
            $display("FAIL final instr_count: got %0d expected %0d", bus.instr_count, exp_count);
        end
    endtask

    initial begin
        steps_of = '{5, 3, 4, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 4,
                     4, 2, 2, 3, 2, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        test_reset();
        test_add();
        test_wait();
        test_random();
        test_stop_halt();
        test_illegal();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Parametrised multicycle control sequencer for the Mini-SRC datapath.
- Generates the fetch strobes with a memory wait-state handshake and a decode cycle.
- Steps a per-opcode execute counter sized from a step-count table.
- Handles HALT/Stop/Resume and flags illegal opcodes and memory timeouts.
- Sits between IR and the combinational control decoder; that decoder drives the execute-phase strobes from {opcode, step}.

Parameters:
- IRW, 32, instruction register width.
- OPW, 5, opcode width; opcode field = IR[IRW-1 -: OPW].
- STEPW, 3, execute step counter width (maximum 2^STEPW - 1 steps).
- STEP_TABLE, STEP_TABLE_DEF, packed 2^OPW x STEPW vector; entry k = execute step count of opcode k; 0 = illegal.
- HALT_OP, 5'b11011, halt opcode.
- MEM_WAIT, 1, 1 = F1 waits on Mem_Ready; 0 = single-cycle memory, Mem_Ready ignored.
- MEM_TIMEOUT, 15, maximum F1 wait cycles before bus error.
- CNTW, 32, retired-instruction counter width.

Ports:
- Clock, in, 1, system clock (rising edge).
- Reset, in, 1, asynchronous, active-high reset.
- IR, in, IRW, instruction register contents.
- Mem_Ready, in, 1, memory read data valid.
- Stop, in, 1, level; stop after the current instruction retires.
- Resume, in, 1, pulse; leave HALT.
- PCout, MARin, IncPC, Zin, out, 1 each, fetch0 strobes.
- Zlowout, PCin, Read, MDRin, out, 1 each, fetch1 strobes.
- MDRout, IRin, out, 1 each, fetch2 strobes.
- exec_valid, out, 1, execute phase active; decoder strobes are legal only while this is high.
- opcode, out, OPW, opcode latched in DEC.
- step, out, STEPW, current execute step, 0-based.
- Run, out, 1, processor running.
- err, out, 2, 00 none, 01 illegal opcode, 10 memory timeout.
- instr_count, out, CNTW, count of retired instructions.

Behaviour:
- States: RST, F0, F1, F2, DEC, EXEC, HALT, ERR. All outputs are registered or Moore-decoded from state.
- Reset (async, any state, including mid-operation):
  - State = RST; every output = 0 immediately.
  - opcode, step, instr_count and err are cleared.
- RST -> F0 on the first clock edge after Reset deasserts.
- F0: PCout, MARin, IncPC, Zin = 1. Next state F1.
- F1: Zlowout, PCin, Read, MDRin = 1.
  - Zlowout and PCin assert only in the first F1 cycle. Read and MDRin hold for every F1 cycle.
  - MEM_WAIT=0: next state F2.
  - MEM_WAIT=1: F1 -> F2 when Mem_Ready is sampled 1. Otherwise a wait counter increments.
  - Wait counter = MEM_TIMEOUT with Mem_Ready still 0: next state ERR, err = 10.
  - Mem_Ready in the same cycle the counter hits the limit: ready wins, next state F2.
- F2: MDRout, IRin = 1. Next state DEC.
- DEC: no strobes.
  - opcode <= IR opcode field.
  - If IR opcode = HALT_OP: next state HALT and instr_count increments.
  - Else if the table entry = 0: next state ERR, err = 01.
  - Else: next state EXEC, step <= 0.
- EXEC: exec_valid = 1. While step < N-1, step increments each cycle (N = table entry).
- EXEC at step = N-1 (retire):
  - instr_count increments; it wraps modulo 2^CNTW.
  - Next state HALT if Stop = 1, else F0.
  - N = 1 therefore gives exactly one EXEC cycle.
- HALT: Run = 0.
  - Resume = 1 and Stop = 0: next state F0.
  - Resume and Stop both 1: Stop wins; stay in HALT.
- ERR: Run = 0, err holds. Leaves only via Reset.
- Run = 1 in F0, F1, F2, DEC and EXEC; Run = 0 in RST, HALT and ERR.
- Stop asserted during fetch or DEC does not abort; the instruction completes.
- Latency: zero-wait fetch + decode = 4 cycles; instruction total = 4 + N + F1 wait cycles.
- Illegal transitions or unreachable state encodings go to RST.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum;
  - the opcode constants (ld 00000 through halt 11011);
  - STEP_TABLE_DEF (ld 5, ldi 3, st 4, add/sub/and/or/ror/rol/shr/shra/shl/addi/andi/ori 3, div/mul 4, neg/not 2, br 3, jal 2, jr/in/out/mflo/mfhi/nop 1, halt 0, 11100-11111 0);
  - the err code constants.
- One sub-module: ctrl_fetch_wait, the F1 wait/timeout counter (inputs: F1 active, Mem_Ready; outputs: ready, timeout).

Test Plan:
- Reset release, IR opcode 00011 (add), Mem_Ready = 1 -> F0, F1, F2, DEC, then EXEC steps 0, 1, 2, then F0 again; instr_count = 1.
- Mem_Ready held low 2 cycles in F1 -> Read/MDRin high 3 cycles, PCin high for 1 cycle only, then F2; err = 00.
- Mem_Ready never asserted, MEM_TIMEOUT = 15 -> ERR after 15 wait cycles; err = 10, Run = 0; stays until Reset.
- IR opcode 11111 -> ERR from DEC, err = 01, exec_valid never asserted.
- Stop raised at EXEC step 1 of mul (N = 4) -> steps 2 and 3 complete, then HALT, Run = 0. Resume pulse with Stop low -> F0. Resume with Stop high -> stays in HALT.
- Reset asserted mid-EXEC of ld at step 3 -> all outputs 0 in the same cycle. After release: RST, then F0; instr_count = 0.
